// File: rtl/fp_pkg.sv
// ------------------------------------------------------------------
// fp_pkg : shared types and helpers for the fp_addsub datapath
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package fp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    ALIGN   = 3'd3,
    ADD     = 3'd4,
    NORM    = 3'd5,
    ROUND   = 3'd6,
    OUT     = 3'd7
  } fp_state_e;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } fp_flags_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to their word width.
  function automatic logic [63:0] qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_lzc.sv
// ------------------------------------------------------------------
// fp_lzc : combinational leading-zero counter (count = WIDTH for all-zero input)
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_lzc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]               value,
  output logic [$clog2(WIDTH+1)-1:0]     count
);

  localparam int CW = $clog2(WIDTH + 1);

  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_addsub.sv
// ------------------------------------------------------------------
// fp_addsub : multi-cycle IEEE-754 add/sub, RNE, valid/ready stream;
//             FP_ADDSUB_DENORM_EN enables subnormals (else flush-to-zero)
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module fp_addsub
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] z,
  output fp_flags_t            flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int MW   = MAN_W + 4;
  localparam int EW   = EXP_W + 2;
  localparam int SW   = $clog2(MW + 1);
  localparam int RW   = MAN_W + 2;
  localparam int BIAS = bias(EXP_W);
`ifdef FP_ADDSUB_DENORM_EN
  localparam bit DENORM = 1'b1;
`else
  localparam bit DENORM = 1'b0;
`endif

  typedef logic signed [EW-1:0] exp_t;
  localparam exp_t EMIN = exp_t'(1 - BIAS);
  localparam exp_t EMAX = exp_t'(BIAS);
  localparam exp_t ONE  = exp_t'(1);
  localparam logic [W-1:0] QNAN = W'(qnan(EXP_W, MAN_W));

  typedef struct packed {
    logic          s;
    exp_t          e;
    logic [MW-1:0] m;
    logic          nan;
    logic          inf;
    logic          zero;
  } unp_t;

  fp_state_e      state;
  logic [W-1:0]   opa, opb;
  logic           sa, sb;
  exp_t           ea, eb;
  logic [MW-1:0]  ma, mb;
  logic           a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [MW:0]    sum;

  // Mantissa layout {hidden, fraction, guard, round, sticky}.
  function automatic unp_t unpack(input logic [W-1:0] x);
    logic [EXP_W-1:0] fe;
    logic [MAN_W-1:0] ff;
    logic             den;
    fe          = x[W-2 -: EXP_W];
    ff          = x[MAN_W-1:0];
    den         = (fe == '0);
    unpack.s    = x[W-1];
    unpack.nan  = (&fe) && (ff != '0);
    unpack.inf  = (&fe) && (ff == '0);
    unpack.zero = den && (!DENORM || ff == '0);
    unpack.m    = {~den, ff, 3'b000};
    unpack.e    = den ? EMIN : exp_t'(fe) - exp_t'(BIAS);
  endfunction

  unp_t ua, ub;
  assign ua = unpack(opa);
  assign ub = unpack(opb);

  logic           spec_hit;
  logic [W-1:0]   spec_z;
  fp_flags_t      spec_f;

  always_comb begin
    spec_hit = 1'b1;
    spec_z   = QNAN;
    spec_f   = '0;
    if (a_nan || b_nan) begin
      spec_z = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      spec_z         = QNAN;
      spec_f.invalid = 1'b1;
    end else if (a_inf) begin
      spec_z = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_z = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_zero && b_zero) begin
      spec_z = {sa & sb, {(W-1){1'b0}}};
    end else if (a_zero) begin
      spec_z = opb;
    end else if (b_zero) begin
      spec_z = opa;
    end else begin
      spec_hit = 1'b0;
    end
  end

  exp_t           diff, dabs;
  logic           a_big;
  logic [SW-1:0]  sh;
  logic [MW-1:0]  small_in, aligned;

  always_comb begin
    diff     = ea - eb;
    a_big    = ~diff[EW-1];
    dabs     = a_big ? diff : -diff;
    sh       = (dabs > exp_t'(MW)) ? SW'(MW) : SW'(dabs);
    small_in = a_big ? mb : ma;
    aligned  = (small_in >> sh) | MW'(|(small_in & ~({MW{1'b1}} << sh)));
  end

  logic           same, ge, sign_c;
  logic [MW:0]    sum_c;

  always_comb begin
    same = (sa == sb);
    ge   = (ma >= mb);
    if (same) begin
      sum_c  = {1'b0, ma} + {1'b0, mb};
      sign_c = sa;
    end else if (ge) begin
      sum_c  = {1'b0, ma} - {1'b0, mb};
      sign_c = (ma == mb) ? 1'b0 : sa;
    end else begin
      sum_c  = {1'b0, mb} - {1'b0, ma};
      sign_c = sb;
    end
  end

  logic [SW-1:0]  lz, lsh;
  exp_t           room, e_norm;
  logic [MW-1:0]  m_norm;

  fp_lzc #(.WIDTH(MW)) u_lzc (
    .value (sum[MW-1:0]),
    .count (lz)
  );

  // With subnormals enabled the shift stops at the minimum exponent.
  always_comb begin
    room = ea - EMIN;
    lsh  = (DENORM && (exp_t'(lz) > room)) ? SW'(room) : lz;
    if (sum[MW]) begin
      m_norm = {sum[MW:2], sum[1] | sum[0]};
      e_norm = ea + ONE;
    end else begin
      m_norm = sum[MW-1:0] << lsh;
      e_norm = ea - exp_t'(lsh);
    end
  end

  logic           inc, carry, hid, tiny, inexact;
  logic [RW-1:0]  rnd;
  logic [MAN_W-1:0] frac;
  exp_t           e_fin;
  logic [W-1:0]   z_c;
  fp_flags_t      flags_c;

  always_comb begin
    inc     = ma[2] & (ma[1] | ma[0] | ma[3]);
    rnd     = {1'b0, ma[MW-1:3]} + RW'(inc);
    carry   = rnd[MAN_W+1];
    hid     = carry | rnd[MAN_W];
    frac    = carry ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    e_fin   = carry ? ea + ONE : ea;
    tiny    = ~ma[MW-1] | (ea < EMIN);
    inexact = |ma[2:0];
    z_c     = {sa, (hid ? EXP_W'(e_fin + exp_t'(BIAS)) : {EXP_W{1'b0}}), frac};
    flags_c = '0;
    flags_c.underflow = tiny & inexact;
    flags_c.inexact   = inexact;
    if (ma == '0) begin
      z_c     = {sa, {(W-1){1'b0}}};
      flags_c = '0;
    end else if (!DENORM && tiny) begin
      z_c               = {sa, {(W-1){1'b0}}};
      flags_c.underflow = 1'b1;
      flags_c.inexact   = 1'b1;
    end else if (e_fin > EMAX) begin
      z_c               = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_c.overflow  = 1'b1;
      flags_c.underflow = 1'b0;
      flags_c.inexact   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      z         <= '0;
      flags     <= '0;
      opa       <= '0;
      opb       <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      ea        <= '0;
      eb        <= '0;
      ma        <= '0;
      mb        <= '0;
      a_nan     <= 1'b0;
      b_nan     <= 1'b0;
      a_inf     <= 1'b0;
      b_inf     <= 1'b0;
      a_zero    <= 1'b0;
      b_zero    <= 1'b0;
      sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opa      <= a;
            opb      <= b ^ {sub, {(W-1){1'b0}}};
            in_ready <= 1'b0;
            state    <= UNPACK;
          end else begin
            in_ready <= 1'b1;
          end
        end
        UNPACK: begin
          sa     <= ua.s;    sb     <= ub.s;
          ea     <= ua.e;    eb     <= ub.e;
          ma     <= ua.m;    mb     <= ub.m;
          a_nan  <= ua.nan;  b_nan  <= ub.nan;
          a_inf  <= ua.inf;  b_inf  <= ub.inf;
          a_zero <= ua.zero; b_zero <= ub.zero;
          state  <= SPECIAL;
        end
        SPECIAL: begin
          if (spec_hit) begin
            z         <= spec_z;
            flags     <= spec_f;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sa    <= a_big ? sa : sb;
          sb    <= a_big ? sb : sa;
          ma    <= a_big ? ma : mb;
          mb    <= aligned;
          ea    <= a_big ? ea : eb;
          state <= ADD;
        end
        ADD: begin
          sum   <= sum_c;
          sa    <= sign_c;
          state <= NORM;
        end
        NORM: begin
          ma    <= m_norm;
          ea    <= e_norm;
          state <= ROUND;
        end
        ROUND: begin
          z         <= z_c;
          flags     <= flags_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub.sv
// ------------------------------------------------------------------
// tb_fp_addsub : scoreboard bench for fp32 and bf16 instances of fp_addsub
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_fp_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid;
  logic [31:0] a = '0, b = '0, z;
  logic [3:0]  flags;

  logic        h_in_valid = 1'b0, h_sub = 1'b0, h_out_ready = 1'b1;
  logic        h_in_ready, h_out_valid;
  logic [15:0] h_a = '0, h_b = '0, h_z;
  logic [3:0]  h_flags;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] z; logic [3:0] fl; int lat; string name; } sb_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [31:0] z; logic [3:0] fl; int lat; string name; } vec_t;
  typedef struct { logic [15:0] z; logic [3:0] fl; } hsb_t;

  sb_t  sb[$];
  hsb_t hsb[$];

  fp_addsub #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .flags(flags)
  );

  fp_addsub #(.EXP_W(8), .MAN_W(7)) dut16 (
    .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .a(h_a), .b(h_b), .sub(h_sub), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .z(h_z), .flags(h_flags)
  );

  task automatic send32(input vec_t v, input bit push);
    bit rdy;
    if (push) sb.push_back('{v.z, v.fl, v.lat, v.name});
    a = v.a; b = v.b; sub = v.s; in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait32(output int lat, output bit tmo);
    lat = 0; tmo = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (out_valid) begin tmo = 1'b0; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (z !== 32'h0) begin failures++; $display("FAIL reset_z: got %h want 00000000", z); end
    checks++; if (flags !== 4'h0) begin failures++; $display("FAIL reset_flags: got %b want 0000", flags); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith;
    vec_t vq[$];
    vq.push_back('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6, "one_plus_two"});
    vq.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 6, "one_minus_one"});
    vq.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2, "negzero_sum"});
    vq.push_back('{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 2, "inf_minus_inf"});
    vq.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6, "overflow"});
    vq.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6, "rne_tie_even"});
    vq.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 6, "rne_tie_odd"});
    vq.push_back('{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6, "neg_result"});
    vq.push_back('{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, 6, "three_minus_one"});
    vq.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2, "nan_in"});
    vq.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2, "inf_plus_one"});
    vq.push_back('{32'h00000000, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000, 2, "zero_plus_one"});
`ifdef FP_ADDSUB_DENORM_EN
    vq.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 6, "subnormal_sum"});
    vq.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000, 6, "gradual_underflow"});
`else
    vq.push_back('{32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000, 2, "subnormal_sum"});
    vq.push_back('{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 6, "flush_underflow"});
`endif
    out_ready = 1'b1;
    foreach (vq[i]) begin
      sb_t e;
      int  lat;
      bit  tmo;
      send32(vq[i], 1'b1);
      wait32(lat, tmo);
      e = sb.pop_front();
      checks++;
      if (tmo !== 1'b0) begin
        failures++; $display("FAIL %s timeout: out_valid never rose, want latency %0d", e.name, e.lat);
      end else begin
        checks++; if (z !== e.z) begin failures++; $display("FAIL %s z: got %h want %h", e.name, z, e.z); end
        checks++; if (flags !== e.fl) begin failures++; $display("FAIL %s flags: got %b want %b", e.name, flags, e.fl); end
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++; $display("FAIL %s back_to_back: out_valid=%b in_ready=%b want 0 1", e.name, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_handshake;
    sb_t e;
    int  lat;
    bit  tmo;
    out_ready = 1'b0;
    send32('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6, "stall"}, 1'b1);
    wait32(lat, tmo);
    e = sb.pop_front();
    checks++;
    if (tmo !== 1'b0) begin failures++; $display("FAIL stall timeout: out_valid never rose"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || z !== e.z || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold cycle %0d: out_valid=%b z=%h in_ready=%b want 1 %h 0", c, out_valid, z, in_ready, e.z);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_abort;
    bit seen;
    out_ready = 1'b1;
    send32('{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6, "aborted"}, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL abort_ready_after: got %b want 1", in_ready); end
    seen = 1'b0;
    repeat (10) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL abort_discard: out_valid=%b seen, want 0", seen); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_empty: got %0d want 0", sb.size()); end
  endtask

  task automatic test_bf16;
    logic [15:0] av[2] = '{16'h3F80, 16'h3F80};
    logic [15:0] bv[2] = '{16'h3F80, 16'h3F00};
    logic        sv[2] = '{1'b0, 1'b1};
    logic [15:0] zv[2] = '{16'h4000, 16'h3F00};
    h_out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      hsb_t e;
      bit   rdy;
      int   lat;
      hsb.push_back('{zv[k], 4'b0000});
      h_a = av[k]; h_b = bv[k]; h_sub = sv[k]; h_in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
        rdy = h_in_ready;
        @(posedge clk); #1;
        if (rdy) break;
      end
      h_in_valid = 1'b0;
      lat = 0;
      while (!h_out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      e = hsb.pop_front();
      checks++; if (h_out_valid !== 1'b1) begin failures++; $display("FAIL bf16_%0d timeout: no out_valid", k); end
      checks++; if (h_z !== e.z) begin failures++; $display("FAIL bf16_%0d z: got %h want %h", k, h_z, e.z); end
      checks++; if (h_flags !== e.fl) begin failures++; $display("FAIL bf16_%0d flags: got %b want %b", k, h_flags, e.fl); end
      checks++; if (lat !== 6) begin failures++; $display("FAIL bf16_%0d latency: got %0d want 6", k, lat); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arith();
    test_handshake();
    test_abort();
    test_bf16();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
